call_stack_ras: RTL and testbench
=================================

CALL_STACK_RAS -- requirements
Module: call_stack_ras

Interface
REQ-001 SHALL have parameter DATA_W, default 19, entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of entries (power of two, >=4).
REQ-003 SHALL have parameter OVF_WRAP, default 0, full-push policy (0 = reject, 1 = circular overwrite of oldest).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port push  input  1  push request (call).
REQ-007 SHALL have port push_data  input  DATA_W  value to push (return address).
REQ-008 SHALL have port pop  input  1  pop request (return).
REQ-009 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-010 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-011 SHALL have port top_data  output  DATA_W  current top-of-stack value, 0 when empty.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  valid entry count.
REQ-013 SHALL have ports full and empty, each output 1: count==DEPTH and count==0.
REQ-014 SHALL have ports overflow and underflow, each output 1: sticky error flags.

Function
REQ-015 SHALL hold an internal pointer sp (next free slot, $clog2(DEPTH) bits, wraps modulo DEPTH) and DEPTH x DATA_W storage.
REQ-016 SHALL apply all state changes on the rising clk edge; top_data, count, full, empty and the flags SHALL reflect the new state immediately after that edge (zero-cycle read of top, one-edge update latency).
REQ-017 Priority SHALL be: flush > push&pop > push > pop.
REQ-018 flush SHALL set sp=0 and count=0, ignore push/pop that cycle, and leave overflow/underflow unchanged.
REQ-019 push only, not full: mem[sp]<=push_data, sp+1, count+1.
REQ-020 push only, full, OVF_WRAP=0: storage, sp and count unchanged; overflow set.
REQ-021 push only, full, OVF_WRAP=1: mem[sp]<=push_data, sp+1 (wrap), count stays DEPTH; overflow set.
REQ-022 pop only, not empty: sp-1, count-1; popped entry is not cleared.
REQ-023 pop only, empty: no state change; underflow set.
REQ-024 push&pop, count>=1: mem[sp-1]<=push_data (replace top); sp and count unchanged; no flag change.
REQ-025 push&pop, count==0: behave as push only; no underflow.
REQ-026 top_data SHALL equal mem[sp-1] when count>0, else 0.
REQ-027 clr_err SHALL clear both flags; a flag set event in the same cycle SHALL win over clr_err.
REQ-028 count SHALL never exceed DEPTH nor wrap below 0 under any input sequence.

Reset
REQ-029 rst_n low SHALL asynchronously force sp=0, count=0, empty=1, full=0, overflow=0, underflow=0, top_data=0.
REQ-030 Storage contents SHALL NOT be reset; reset asserted mid-operation SHALL discard any in-flight push/pop that cycle.
REQ-031 After rst_n deasserts, the first rising edge SHALL accept operations normally.

Verification
REQ-032 Push 0x00010, 0x00020, 0x00030 -> count=3, top_data=0x00030; pop -> top_data=0x00020, count=2.
REQ-033 DEPTH=4, OVF_WRAP=0: push 1..5 -> count=4, full=1, overflow=1, top_data=4; four pops return 4,3,2,1, empty=1.
REQ-034 DEPTH=4, OVF_WRAP=1: push 1..5 -> count=4, overflow=1, top_data=5; pops return 5,4,3,2.
REQ-035 Empty stack: pop -> underflow=1, count=0; pop with clr_err same cycle -> underflow stays 1; clr_err alone -> 0.
REQ-036 Stack holding 0x00AAA: push 0x00BBB with pop -> count unchanged, top_data=0x00BBB; push 5 then flush with push -> count=0, empty=1, flags unchanged.
REQ-037 Push 3 entries, assert rst_n low between edges -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/call_stack_ras.sv
// call_stack_ras: return-address stack with flush, sticky overflow/underflow
// flags and a selectable reject/overwrite policy on full push.
module call_stack_ras #(
    parameter int DATA_W   = 19,
    parameter int DEPTH    = 256,
    parameter int OVF_WRAP = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          top_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     sp_q, sp_d, top_idx, wr_idx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              wr_en, ovf_set, udf_set, is_full, is_empty;

    assign is_full  = cnt_q == CW'(DEPTH);
    assign is_empty = cnt_q == '0;
    assign top_idx  = sp_q - AW'(1);

    always_comb begin
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = sp_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (flush) begin
            sp_d  = '0;
            cnt_d = '0;
        end else if (push && pop && !is_empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            // A pop paired with a push on an empty stack degrades to a plain push.
            if (!is_full) begin
                wr_en = 1'b1;
                sp_d  = sp_q + AW'(1);
                cnt_d = cnt_q + CW'(1);
            end else begin
                ovf_set = 1'b1;
                if (OVF_WRAP != 0) begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + AW'(1);
                end
            end
        end else if (pop) begin
            if (!is_empty) begin
                sp_d  = top_idx;
                cnt_d = cnt_q - CW'(1);
            end else begin
                udf_set = 1'b1;
            end
        end
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        udf_d = udf_set | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage is deliberately unreset; a write landing during reset is invisible
    // because sp and count restart at zero.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= push_data;
    end

    assign top_data  = is_empty ? '0 : mem_q[top_idx];
    assign count     = cnt_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
endmodule

// File: tb/tb_call_stack_ras.sv
// tb_call_stack_ras: directed checks on a default-size stack and two 4-deep
// stacks (reject and overwrite policies) sharing one stimulus bus.
module tb_call_stack_ras;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [18:0] push_data = '0;

    logic [18:0] m_top, n_top, w_top;
    logic [8:0]  m_cnt;
    logic [2:0]  n_cnt, w_cnt;
    logic        m_full, m_empty, m_ovf, m_udf;
    logic        n_full, n_empty, n_ovf, n_udf;
    logic        w_full, w_empty, w_ovf, w_udf;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    call_stack_ras u_main (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
        .flush(flush), .clr_err(clr_err), .top_data(m_top), .count(m_cnt),
        .full(m_full), .empty(m_empty), .overflow(m_ovf), .underflow(m_udf)
    );

    call_stack_ras #(.DEPTH(4), .OVF_WRAP(0)) u_rej (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
        .flush(flush), .clr_err(clr_err), .top_data(n_top), .count(n_cnt),
        .full(n_full), .empty(n_empty), .overflow(n_ovf), .underflow(n_udf)
    );

    call_stack_ras #(.DEPTH(4), .OVF_WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
        .flush(flush), .clr_err(clr_err), .top_data(w_top), .count(w_cnt),
        .full(w_full), .empty(w_empty), .overflow(w_ovf), .underflow(w_udf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Apply one cycle of stimulus, then sample 1ns after the edge.
    task automatic cyc(input logic pu, input logic po, input logic fl, input logic ce,
                       input logic [18:0] d);
        push = pu; pop = po; flush = fl; clr_err = ce; push_data = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_count", 32'(m_cnt), 0);
        chk("rst_empty", 32'(m_empty), 1);
        chk("rst_full", 32'(m_full), 0);
        chk("rst_ovf", 32'(m_ovf), 0);
        chk("rst_udf", 32'(m_udf), 0);
        chk("rst_top", 32'(m_top), 0);
        rst_n = 1'b1;

        cyc(1, 0, 0, 0, 19'h00010);
        chk("first_push_count", 32'(m_cnt), 1);
        cyc(1, 0, 0, 0, 19'h00020);
        cyc(1, 0, 0, 0, 19'h00030);
        chk("push3_count", 32'(m_cnt), 3);
        chk("push3_top", 32'(m_top), 32'h30);
        cyc(0, 1, 0, 0, '0);
        chk("pop_top", 32'(m_top), 32'h20);
        chk("pop_count", 32'(m_cnt), 2);

        cyc(0, 0, 1, 0, '0);
        chk("flush_count", 32'(m_cnt), 0);
        cyc(1, 0, 0, 0, 19'h00AAA);
        cyc(1, 1, 0, 0, 19'h00BBB);
        chk("replace_count", 32'(m_cnt), 1);
        chk("replace_top", 32'(m_top), 32'hBBB);
        chk("replace_udf", 32'(m_udf), 0);
        cyc(1, 0, 0, 0, 19'h00005);
        chk("push5_top", 32'(m_top), 5);
        cyc(1, 0, 1, 0, 19'h00077);
        chk("flushpush_count", 32'(m_cnt), 0);
        chk("flushpush_empty", 32'(m_empty), 1);
        chk("flushpush_top", 32'(m_top), 0);
        chk("flushpush_ovf", 32'(m_ovf), 0);
        chk("flushpush_udf", 32'(m_udf), 0);

        cyc(0, 1, 0, 0, '0);
        chk("uf_flag", 32'(m_udf), 1);
        chk("uf_count", 32'(m_cnt), 0);
        cyc(0, 1, 0, 1, '0);
        chk("uf_beats_clr", 32'(m_udf), 1);
        cyc(0, 0, 0, 1, '0);
        chk("clr_err", 32'(m_udf), 0);
        cyc(1, 1, 0, 0, 19'h00123);
        chk("pp_empty_count", 32'(m_cnt), 1);
        chk("pp_empty_top", 32'(m_top), 32'h123);
        chk("pp_empty_udf", 32'(m_udf), 0);

        cyc(0, 0, 1, 0, '0);
        cyc(1, 0, 0, 0, 19'h00001);
        cyc(1, 0, 0, 0, 19'h00002);
        cyc(1, 0, 0, 0, 19'h00003);
        chk("pre_rst_count", 32'(m_cnt), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(m_cnt), 0);
        chk("async_rst_top", 32'(m_top), 0);
        chk("async_rst_empty", 32'(m_empty), 1);
        #1 rst_n = 1'b1;
        cyc(1, 0, 0, 0, 19'h00007);
        chk("post_rst_count", 32'(m_cnt), 1);
        chk("post_rst_top", 32'(m_top), 7);

        do_reset();
        for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 0, 19'(i));
        chk("rej_count", 32'(n_cnt), 4);
        chk("rej_full", 32'(n_full), 1);
        chk("rej_ovf", 32'(n_ovf), 1);
        chk("rej_top", 32'(n_top), 4);
        chk("wrap_count", 32'(w_cnt), 4);
        chk("wrap_ovf", 32'(w_ovf), 1);
        chk("wrap_top", 32'(w_top), 5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rej_pop%0d", i), 32'(n_top), 32'(4 - i));
            chk($sformatf("wrap_pop%0d", i), 32'(w_top), 32'(5 - i));
            cyc(0, 1, 0, 0, '0);
        end
        chk("rej_empty", 32'(n_empty), 1);
        chk("wrap_empty", 32'(w_empty), 1);
        chk("wrap_drained_top", 32'(w_top), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
